usb_rx_ctrl: RTL and testbench

//  Sequences bs_decoder for one received USB packet at a time.

---
 rtl/usb_rx_ctrl_if.sv | 28 ++
 rtl/usb_rx_ctrl.sv | 165 ++++++++++++++++
 tb/tb_usb_rx_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_ctrl_if.sv
// usb_rx_ctrl bus: raw line input, decoder/CRC status in,
// decoder sequencing and per-packet status out.
interface usb_rx_ctrl_if;
    logic        line_bit;
    logic        line_se0;
    logic        PID_error;
    logic        end_rc_crc;
    logic        crc_ok;
    logic        start_decode;
    logic        end_decode;
    logic        busy;
    logic        pkt_done;
    logic        pkt_ok;
    logic [2:0]  err_code;
    logic [10:0] bit_count;

    modport slave (
        input  line_bit, line_se0, PID_error, end_rc_crc, crc_ok,
        output start_decode, end_decode, busy, pkt_done, pkt_ok,
        output err_code, bit_count
    );

    modport master (
        output line_bit, line_se0, PID_error, end_rc_crc, crc_ok,
        input  start_decode, end_decode, busy, pkt_done, pkt_ok,
        input  err_code, bit_count
    );
endinterface

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: hunts SYNC, frames one packet for bs_decoder,
// waits for the CRC verdict and reports one status per packet.
module usb_rx_ctrl #(
    parameter logic [7:0] SYNC_PAT = 8'b01010100,
    parameter int         MIN_BITS = 8,
    parameter int         MAX_BITS = 1100,
    parameter int         CRC_WAIT = 16,
    parameter int         IDLE_CYC = 4
) (
    input logic          clk,
    input logic          rst,
    usb_rx_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PKT   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [2:0] ERR_OK  = 3'd0;
    localparam logic [2:0] ERR_PID = 3'd1;
    localparam logic [2:0] ERR_OVF = 3'd2;
    localparam logic [2:0] ERR_TMO = 3'd3;
    localparam logic [2:0] ERR_CRC = 3'd4;
    localparam logic [2:0] ERR_SHT = 3'd5;

    localparam logic [10:0] L_MAX = 11'(MAX_BITS);
    localparam logic [10:0] L_MIN = 11'(MIN_BITS);
    localparam logic [7:0]  L_TMO = 8'(CRC_WAIT - 1);
    localparam logic [3:0]  L_IDL = 4'(IDLE_CYC - 1);

    logic [1:0]  r_state;
    logic [6:0]  r_sync;
    logic        r_se0_d;
    logic [10:0] r_cnt;
    logic [7:0]  r_timer;
    logic [3:0]  r_idle;
    logic [2:0]  r_err;
    logic        r_ok;
    logic        r_start;
    logic        r_end;
    logic        r_done;

    logic        w_bit;
    logic [7:0]  w_sync_nxt;
    logic        w_match;
    logic        w_eop;
    logic        w_j;
    logic [2:0]  w_err_w;
    logic [2:0]  w_err_crc;
    logic [2:0]  w_err_tmo;

    // SYNC window, EOP detect and error merging; first error wins
    always_comb begin
        w_bit      = bus.line_se0 | bus.line_bit;
        w_sync_nxt = {r_sync, w_bit};
        w_match    = (w_sync_nxt == SYNC_PAT);
        w_eop      = bus.line_se0 & r_se0_d;
        w_j        = bus.line_bit & ~bus.line_se0;
        w_err_w    = (r_err != ERR_OK) ? r_err :
                     (bus.PID_error ? ERR_PID : ERR_OK);
        w_err_crc  = (w_err_w != ERR_OK) ? w_err_w :
                     (bus.crc_ok ? ERR_OK : ERR_CRC);
        w_err_tmo  = (w_err_w != ERR_OK) ? w_err_w : ERR_TMO;
    end

    // Packet sequencer: IDLE -> PKT -> WAIT_CRC/DRAIN -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sync  <= 7'h7F;
            r_se0_d <= 1'b0;
            r_cnt   <= 11'd0;
            r_timer <= 8'd0;
            r_idle  <= 4'd0;
            r_err   <= ERR_OK;
            r_ok    <= 1'b0;
            r_start <= 1'b0;
            r_end   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_end   <= 1'b0;
            r_done  <= 1'b0;
            r_se0_d <= bus.line_se0;
            case (r_state)
                S_IDLE: begin
                    r_sync <= w_sync_nxt[6:0];
                    if (w_match) begin
                        r_start <= 1'b1;
                        r_state <= S_PKT;
                        r_cnt   <= 11'd0;
                        r_err   <= ERR_OK;
                        r_ok    <= 1'b0;
                        r_sync  <= 7'h7F;
                    end
                end
                S_PKT: begin
                    if (!bus.line_se0 && r_cnt != L_MAX)
                        r_cnt <= r_cnt + 11'd1;
                    if (bus.PID_error) begin
                        r_err   <= ERR_PID;
                        r_end   <= 1'b1;
                        r_idle  <= 4'd0;
                        r_state <= S_DRAIN;
                    end else if (r_cnt == L_MAX) begin
                        r_err   <= ERR_OVF;
                        r_end   <= 1'b1;
                        r_idle  <= 4'd0;
                        r_state <= S_DRAIN;
                    end else if (w_eop) begin
                        r_end <= 1'b1;
                        if (r_cnt < L_MIN) begin
                            r_err   <= ERR_SHT;
                            r_idle  <= 4'd0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_timer <= 8'd0;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_timer <= r_timer + 8'd1;
                    if (bus.end_rc_crc) begin
                        r_err   <= w_err_crc;
                        r_ok    <= (w_err_crc == ERR_OK);
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_timer == L_TMO) begin
                        r_err   <= w_err_tmo;
                        r_ok    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_err <= w_err_w;
                    end
                end
                default: begin
                    if (r_end) begin
                        r_done <= 1'b1;
                        r_ok   <= 1'b0;
                    end
                    if (w_j) begin
                        if (r_idle == L_IDL) begin
                            r_idle  <= 4'd0;
                            r_state <= S_IDLE;
                        end else begin
                            r_idle <= r_idle + 4'd1;
                        end
                    end else begin
                        r_idle <= 4'd0;
                    end
                end
            endcase
        end
    end

    assign bus.start_decode = r_start;
    assign bus.end_decode   = r_end;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.pkt_done     = r_done;
    assign bus.pkt_ok       = r_ok;
    assign bus.err_code     = r_err;
    assign bus.bit_count    = r_cnt;
endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed bench for usb_rx_ctrl; expected packet status is queued
// when a packet is driven and checked when pkt_done fires.
module tb_usb_rx_ctrl;
    typedef struct {
        logic [2:0] err;
        logic       ok;
        int         cnt;
        int         dly;
    } exp_t;

    logic clk;
    logic rst;
    usb_rx_ctrl_if bus();

    usb_rx_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    exp_t e;
    int   n_vec   = 0;
    int   n_err   = 0;
    int   n_start = 0;
    int   n_end   = 0;
    int   n_done  = 0;
    int   ncyc    = 0;
    int   t_end   = 0;
    logic pid_first = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: pulse counting, start alignment and scoreboard pop
    always @(negedge clk) begin
        ncyc++;
        if (!rst) begin
            if (bus.start_decode || pid_first)
                chk("start_on_pid", 32'(bus.start_decode), 32'(pid_first));
            if (bus.start_decode) n_start++;
            if (bus.end_decode) begin
                n_end++;
                t_end = ncyc;
            end
            if (bus.pkt_done) begin
                n_done++;
                if (q.size() == 0) begin
                    chk("unexpected_done", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    chk("done_err", 32'(bus.err_code), 32'(e.err));
                    chk("done_ok", 32'(bus.pkt_ok), 32'(e.ok));
                    if (e.cnt >= 0)
                        chk("done_cnt", 32'(bus.bit_count), e.cnt);
                    if (e.dly >= 0)
                        chk("done_delay", ncyc - t_end, e.dly);
                end
            end
        end
    end

    task automatic cyc(input logic b, input logic se0);
        bus.line_bit = b;
        bus.line_se0 = se0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
    endtask

    task automatic sync();
        logic [7:0] p;
        p = 8'b01010100;
        for (int i = 0; i < 8; i++) cyc(p[7-i], 1'b0);
    endtask

    task automatic bits(input int n, input logic [7:0] pat,
                        input logic first, input int perr);
        for (int i = 0; i < n; i++) begin
            pid_first     = first && (i == 0);
            bus.PID_error = (i == perr);
            cyc(pat[7-(i%8)], 1'b0);
        end
        pid_first     = 1'b0;
        bus.PID_error = 1'b0;
    endtask

    task automatic eop();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
    endtask

    task automatic crc(input logic okb);
        bus.end_rc_crc = 1'b1;
        bus.crc_ok     = okb;
        cyc(1'b1, 1'b0);
        bus.end_rc_crc = 1'b0;
        bus.crc_ok     = 1'b0;
    endtask

    task automatic push(input logic [2:0] err, input logic ok,
                        input int cnt, input int dly);
        exp_t x;
        x.err = err;
        x.ok  = ok;
        x.cnt = cnt;
        x.dly = dly;
        q.push_back(x);
    endtask

    task automatic counts(input string tag, input int s, input int en,
                          input int d);
        chk({tag, "_starts"}, n_start, s);
        chk({tag, "_ends"}, n_end, en);
        chk({tag, "_dones"}, n_done, d);
    endtask

    initial begin
        rst            = 1'b1;
        bus.line_bit   = 1'b1;
        bus.line_se0   = 1'b0;
        bus.PID_error  = 1'b0;
        bus.end_rc_crc = 1'b0;
        bus.crc_ok     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_start", 32'(bus.start_decode), 0);
        chk("rst_end", 32'(bus.end_decode), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.pkt_done), 0);
        chk("rst_ok", 32'(bus.pkt_ok), 0);
        chk("rst_err", 32'(bus.err_code), 0);
        chk("rst_cnt", 32'(bus.bit_count), 0);
        rst = 1'b0;
        idle(4);

        // good packet: 8 PID + 72 data bits, verdict 3 cycles late
        push(3'd0, 1'b1, 80, 4);
        sync();
        bits(8, 8'hC3, 1'b1, -1);
        chk("t1_busy_pkt", 32'(bus.busy), 1);
        bits(72, 8'hA5, 1'b0, -1);
        eop();
        idle(3);
        crc(1'b1);
        idle(4);
        counts("t1", 1, 1, 1);
        chk("t1_busy", 32'(bus.busy), 0);
        chk("t1_ok_hold", 32'(bus.pkt_ok), 1);

        // PID error on bit 8, drain needs four J cycles
        push(3'd1, 1'b0, -1, 1);
        sync();
        bits(8, 8'hC3, 1'b1, -1);
        bits(12, 8'hA5, 1'b0, 0);
        chk("t2_drain", 32'(bus.busy), 1);
        idle(3);
        chk("t2_drain3", 32'(bus.busy), 1);
        idle(1);
        chk("t2_idle", 32'(bus.busy), 0);
        chk("t2_err_hold", 32'(bus.err_code), 1);
        counts("t2", 2, 2, 2);

        // short packet
        push(3'd5, 1'b0, 5, 1);
        sync();
        bits(5, 8'hC3, 1'b1, -1);
        eop();
        idle(6);
        counts("t3a", 3, 3, 3);

        // CRC timeout
        push(3'd3, 1'b0, 16, 16);
        sync();
        bits(8, 8'hC3, 1'b1, -1);
        bits(8, 8'hA5, 1'b0, -1);
        eop();
        idle(20);
        counts("t3b", 4, 4, 4);
        chk("t3b_busy", 32'(bus.busy), 0);

        // bad CRC
        push(3'd4, 1'b0, 24, 4);
        sync();
        bits(8, 8'hC3, 1'b1, -1);
        bits(16, 8'hA5, 1'b0, -1);
        eop();
        idle(3);
        crc(1'b0);
        idle(4);
        counts("t5a", 5, 5, 5);

        // stray verdicts while idle
        crc(1'b1);
        idle(2);
        crc(1'b0);
        idle(4);
        counts("t5_stray", 5, 5, 5);
        chk("t5_stray_busy", 32'(bus.busy), 0);

        // SYNC pattern inside packet data
        push(3'd0, 1'b1, 24, 4);
        sync();
        bits(8, 8'hC3, 1'b1, -1);
        bits(8, 8'b01010100, 1'b0, -1);
        bits(8, 8'hA5, 1'b0, -1);
        eop();
        idle(3);
        crc(1'b1);
        idle(4);
        counts("t5b", 6, 6, 6);

        // overflow without EOP
        push(3'd2, 1'b0, 1100, 1);
        sync();
        bits(8, 8'hC3, 1'b1, -1);
        bits(1095, 8'hFF, 1'b0, -1);
        idle(6);
        counts("t4", 7, 7, 7);
        chk("t4_sat", 32'(bus.bit_count), 1100);
        chk("t4_err_hold", 32'(bus.err_code), 2);
        chk("t4_busy", 32'(bus.busy), 0);

        // reset mid-packet
        sync();
        bits(8, 8'hC3, 1'b1, -1);
        bits(4, 8'hA5, 1'b0, -1);
        chk("t6_busy_pre", 32'(bus.busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_busy_async", 32'(bus.busy), 0);
        chk("t6_cnt_async", 32'(bus.bit_count), 0);
        chk("t6_err_async", 32'(bus.err_code), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        counts("t6_abort", 8, 7, 7);
        push(3'd0, 1'b1, 16, 4);
        sync();
        bits(8, 8'hC3, 1'b1, -1);
        bits(8, 8'hA5, 1'b0, -1);
        eop();
        idle(3);
        crc(1'b1);
        idle(4);
        counts("t6_recover", 9, 8, 8);

        chk("sb_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
